// File: rtl/ula_pkg.sv
// Shared types and seven-segment helpers for the ULA result display.
// Segments are active-low, bit0 = a .. bit6 = g.
package ula_pkg;

    typedef enum logic [1:0] {IDLE, CONV, SHOW} disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ula_display_bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per cycle, W cycles per word.
// o_done is high during the cycle whose closing edge performs the final shift.
module bin2bcd_seq #(
    parameter int W      = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [W-1:0]          i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int BCD_W = 4 * DIGITS;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [W-1:0]     bin_q,  bin_d;
    logic [BCD_W-1:0] bcd_q,  bcd_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W+W-1:0] shifted;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        if (!busy_q) begin
            if (i_start) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                bin_d  = i_bin;
                bcd_d  = '0;
            end
        end else begin
            bcd_d = shifted[W +: BCD_W];
            bin_d = shifted[W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath holds whatever it had; busy gates every use of it.
    always_ff @(posedge clk) begin
        bin_q <= bin_d;
        bcd_q <= bcd_d;
    end

    assign o_busy = busy_q;
    assign o_done = busy_q && (cnt_q == CNT_W'(W - 1));
    assign o_bcd  = bcd_q;

endmodule

// File: rtl/ula_display.sv
// ULA result reader: accepts a result word, converts it to decimal and drives HEX0..HEX3.
// Optional macro ULA_SIGNED_DISPLAY_EN shows arithmetic results as signed with a minus on HEX2.
module ula_display
    import ula_pkg::*;
#(
    parameter int W      = 6,
    parameter int DIGITS = 2
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_resultado,
    input  logic         i_overflow,
    input  logic         i_zero,
    input  logic         i_modo,
    output logic         o_done,
    output logic         o_led_zero,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX3
);

    disp_state_t state_q, state_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;
    logic        led_zero_q, led_zero_d;
    logic [6:0]  hex0_q, hex0_d;
    logic [6:0]  hex1_q, hex1_d;
    logic [6:0]  hex2_q, hex2_d;
    logic [6:0]  hex3_q, hex3_d;

    logic                accept;
    logic [W-1:0]        conv_val;
    logic                eng_busy;
    logic                eng_done;
    logic [4*DIGITS-1:0] eng_bcd;
    logic [3:0]          units;
    logic [3:0]          tens;

    assign accept = i_valid && (state_q == IDLE) && !eng_busy;

`ifdef ULA_SIGNED_DISPLAY_EN
    logic       neg_in;
    logic       neg_q, neg_d;
    logic [W:0] mag;
    logic       unused_mag_msb;

    assign neg_in   = !i_modo && i_resultado[W-1];
    assign mag      = neg_in ? -{i_resultado[W-1], i_resultado} : {1'b0, i_resultado};
    // Largest magnitude is 2**(W-1), which still fits in W unsigned bits.
    assign conv_val = mag[W-1:0];
    assign unused_mag_msb = mag[W];
`else
    logic unused_modo;

    assign conv_val    = i_resultado;
    assign unused_modo = i_modo;
`endif

    bin2bcd_seq #(
        .W      (W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .i_start (accept),
        .i_bin   (conv_val),
        .o_busy  (eng_busy),
        .o_done  (eng_done),
        .o_bcd   (eng_bcd)
    );

    assign units = eng_bcd[3:0];
    assign tens  = eng_bcd[7:4];

    always_comb begin
        state_d    = state_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        led_zero_d = led_zero_q;
        hex0_d     = hex0_q;
        hex1_d     = hex1_q;
        hex2_d     = hex2_q;
        hex3_d     = hex3_q;
`ifdef ULA_SIGNED_DISPLAY_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                    ovf_d   = i_overflow;
                    zero_d  = i_zero;
`ifdef ULA_SIGNED_DISPLAY_EN
                    neg_d   = neg_in;
`endif
                end
            end
            CONV: begin
                if (eng_done) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                hex0_d     = seg_encode(units);
                hex1_d     = (tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
`ifdef ULA_SIGNED_DISPLAY_EN
                hex2_d     = neg_q ? SEG_MINUS : SEG_BLANK;
`else
                hex2_d     = SEG_BLANK;
`endif
                hex3_d     = ovf_q ? SEG_E : SEG_BLANK;
                led_zero_d = zero_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= IDLE;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            led_zero_q <= 1'b0;
            hex0_q     <= SEG_BLANK;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
            hex3_q     <= SEG_BLANK;
`ifdef ULA_SIGNED_DISPLAY_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            led_zero_q <= led_zero_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
`ifdef ULA_SIGNED_DISPLAY_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_done     = done_q;
    assign o_led_zero = led_zero_q;
    assign HEX0       = hex0_q;
    assign HEX1       = hex1_q;
    assign HEX2       = hex2_q;
    assign HEX3       = hex3_q;

endmodule

// File: tb/tb_ula_display.sv
// Bench for ula_display: directed cases plus random words checked against a decimal reference.
module tb_ula_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic [5:0] i_resultado;
    logic       i_overflow;
    logic       i_zero;
    logic       i_modo;
    logic       o_done;
    logic       o_led_zero;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

`ifdef ULA_SIGNED_DISPLAY_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    ula_display #(.W(6), .DIGITS(2)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_resultado (i_resultado),
        .i_overflow  (i_overflow),
        .i_zero      (i_zero),
        .i_modo      (i_modo),
        .o_done      (o_done),
        .o_led_zero  (o_led_zero),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_hex0"}, {25'd0, HEX0}, 32'h7F);
        chk({tag, "_hex1"}, {25'd0, HEX1}, 32'h7F);
        chk({tag, "_hex2"}, {25'd0, HEX2}, 32'h7F);
        chk({tag, "_hex3"}, {25'd0, HEX3}, 32'h7F);
    endtask

    // Sends one word, optionally pokes i_valid mid-conversion, then checks timing and display.
    task automatic run_word(input string tag, input logic [5:0] val, input logic ovf,
                            input logic zero, input logic modo, input int glitch_at);
        int  lat;
        int  ready_hi;
        int  mag;
        bit  neg;
        logic [6:0] e0, e1, e2, e3;

        for (int i = 0; i < 20 && !o_ready; i++) step();
        chk({tag, "_ready_in"}, {31'd0, o_ready}, 32'd1);

        i_resultado = val;
        i_overflow  = ovf;
        i_zero      = zero;
        i_modo      = modo;
        i_valid     = 1'b1;
        step();
        i_valid     = 1'b0;
        i_resultado = 6'($urandom);
        i_overflow  = 1'($urandom);
        i_zero      = 1'($urandom);
        i_modo      = 1'($urandom);

        lat = 0;
        ready_hi = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == glitch_at) begin
                i_valid     = 1'b1;
                i_resultado = 6'd5;
            end
            step();
            i_valid = 1'b0;
            if (o_done) begin
                lat = k;
                break;
            end
            if (o_ready) ready_hi++;
        end

        neg = SIGNED_EN && !modo && val[5];
        mag = neg ? 64 - int'(val) : int'(val);
        e0  = seg_tab[mag % 10];
        e1  = (mag / 10 == 0) ? 7'h7F : seg_tab[mag / 10];
        e2  = neg ? 7'h3F : 7'h7F;
        e3  = ovf ? 7'h06 : 7'h7F;

        chk({tag, "_latency"},  lat,      32'd7);
        chk({tag, "_ready_lo"}, ready_hi, 32'd0);
        chk({tag, "_hex0"}, {25'd0, HEX0}, {25'd0, e0});
        chk({tag, "_hex1"}, {25'd0, HEX1}, {25'd0, e1});
        chk({tag, "_hex2"}, {25'd0, HEX2}, {25'd0, e2});
        chk({tag, "_hex3"}, {25'd0, HEX3}, {25'd0, e3});
        chk({tag, "_led"},  {31'd0, o_led_zero}, {31'd0, zero});
        chk({tag, "_ready_done"}, {31'd0, o_ready}, 32'd1);
        step();
        chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_hold_hex0"}, {25'd0, HEX0}, {25'd0, e0});
    endtask

    initial begin
        int done_seen;

        reset       = 1'b0;
        i_valid     = 1'b0;
        i_resultado = '0;
        i_overflow  = 1'b0;
        i_zero      = 1'b0;
        i_modo      = 1'b0;

        step();
        step();
        chk_blank("rst");
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_done",  {31'd0, o_done},  32'd0);
        chk("rst_led",   {31'd0, o_led_zero}, 32'd0);
        reset = 1'b1;
        step();

        run_word("d42", 6'd42, 1'b0, 1'b0, 1'b1, 0);
        run_word("d63", 6'd63, 1'b1, 1'b0, 1'b1, 0);
        run_word("d0",  6'd0,  1'b0, 1'b1, 1'b1, 0);
        run_word("busy_ign", 6'd42, 1'b0, 1'b0, 1'b1, 3);

        // Reset arrives at edge 4 of a conversion.
        i_resultado = 6'd42;
        i_modo      = 1'b1;
        i_overflow  = 1'b1;
        i_valid     = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_blank("midrst");
        chk("midrst_ready", {31'd0, o_ready}, 32'd1);
        chk("midrst_done",  {31'd0, o_done},  32'd0);
        chk("midrst_led",   {31'd0, o_led_zero}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 32'd0);
        chk_blank("midrst_after");

        run_word("neg59", 6'b111011, 1'b0, 1'b0, 1'b0, 0);
        run_word("log59", 6'b111011, 1'b0, 1'b0, 1'b1, 0);
        run_word("neg32", 6'd32, 1'b1, 1'b0, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            run_word("rnd", 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
